shared_timer_arbiter: RTL

Round-robin arbiter and sequencer that shares one BITS-wide down-counter among REQS requesters. A winning requester's duration is loaded into the counter and counted to zero. The winner then receives a one-cycle completion pulse. The block sits alongside the counter library and lets several control blocks share one timing resource instead of each instantiating its own counter.

---
 rtl/shared_timer_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter that shares one down-counter among several requesters.
// The winner's duration is counted to zero, then the winner gets a one-cycle done pulse.
module shared_timer_arbiter #(
  parameter int unsigned REQS = 4,
  parameter int unsigned BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQS-1:0]      req_i,
  input  logic [REQS*BITS-1:0] dur_i,
  input  logic                 abort_i,
  output logic [REQS-1:0]      gnt_o,
  output logic [REQS-1:0]      done_o,
  output logic                 busy_o,
  output logic [BITS-1:0]      count_o
);

  localparam int unsigned PW = (REQS > 1) ? $clog2(REQS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [REQS-1:0] gnt_q, gnt_d;
  logic [REQS-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [BITS-1:0] count_q, count_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [REQS-1:0] win_oh;
  logic [BITS-1:0] win_dur;

  // Scan upward from ptr_q+1, wrapping, so the last winner is considered last.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    found   = 1'b0;
    win     = ptr_q;
    win_oh  = '0;
    win_dur = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 1; i <= int'(REQS); i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(REQS)) begin
        sum = sum - (PW+1)'(REQS);
      end
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        win         = idx;
        win_oh[idx] = 1'b1;
      end
    end
    for (int j = 0; j < int'(REQS); j++) begin
      if (win_oh[j]) begin
        win_dur = dur_i[j*BITS +: BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StRun;
          gnt_d   = win_oh;
          count_d = win_dur;
          ptr_d   = win;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        // Abort takes precedence over completion, so no done pulse on abort.
        if (abort_i) begin
          state_d = StIdle;
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = StDone;
          done_d  = gnt_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q - BITS'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= PW'(REQS - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule
